// File: rtl/arith_sched_pkg.sv
// Shared op codes and FSM state encoding for the arithmetic request scheduler.
package arith_sched_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/arith_div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module arith_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        if (start) begin
            cnt_d = CW'(WIDTH);
            quo_d = a;
            rem_d = '0;
            dvs_d = b;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            // Top bit of trial set means the subtraction borrowed: restore.
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
    end

    assign done = (cnt_q == CW'(1));
    assign quot = quo_q;
    assign rem  = rem_q;

endmodule

// File: rtl/arith_req_scheduler.sv
// Round-robin shared add/sub/mul/div/mod unit: one accepted request in flight,
// result returned with the requester index.
module arith_req_scheduler
    import arith_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0]    req_a,
    input  logic [WIDTH*NREQ-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_err
);

    localparam int IDW = $clog2(NREQ);

    // Single-cycle ops plus the error cases; bit 2*WIDTH is the error flag.
    function automatic logic [2*WIDTH:0] fast_calc(input logic [OP_W-1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] r;
        logic               e;
        r = '0;
        e = 1'b0;
        case (op)
            OP_ADD:  r[WIDTH:0] = {1'b0, a} + {1'b0, b};
            OP_SUB:  r[WIDTH:0] = {1'b0, a} - {1'b0, b};
            OP_MUL:  r = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            OP_DIV:  begin r[WIDTH-1:0] = '1; e = 1'b1; end
            OP_MOD:  begin r[WIDTH-1:0] = a;  e = 1'b1; end
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [IDW-1:0]      gnt_idx;
    logic [IDW:0]        pos;
    logic                gnt_found;
    logic                idle;
    logic                accept;

    logic [WIDTH-1:0]    a_arr  [NREQ];
    logic [WIDTH-1:0]    b_arr  [NREQ];
    logic [OP_W-1:0]     op_arr [NREQ];
    logic [WIDTH-1:0]    sel_a, sel_b;
    logic [OP_W-1:0]     sel_op;
    logic                sel_use_div;
    logic [2*WIDTH:0]    fast;

    logic [IDW-1:0]      id_q;
    logic [2*WIDTH-1:0]  res_q;
    logic                err_q;
    logic                use_div_q;
    logic                is_mod_q;

    logic                div_start;
    logic                div_done;
    logic [WIDTH-1:0]    div_quot, div_rem;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]  = req_a[i*WIDTH +: WIDTH];
            b_arr[i]  = req_b[i*WIDTH +: WIDTH];
            op_arr[i] = req_op[i*OP_W +: OP_W];
        end
    end

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_q} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
            if (!gnt_found && req_valid[pos[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = pos[IDW-1:0];
            end
        end
    end

    assign idle   = (state_q == IDLE) && !rst;
    assign accept = idle && gnt_found;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (gnt_idx == IDW'(i));
        end
    end

    assign sel_a       = a_arr[gnt_idx];
    assign sel_b       = b_arr[gnt_idx];
    assign sel_op      = op_arr[gnt_idx];
    assign sel_use_div = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b != '0);
    assign fast        = fast_calc(sel_op, sel_a, sel_b);
    assign div_start   = accept && sel_use_div;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (accept) begin
            rr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
        case (state_q)
            IDLE:    if (accept) state_d = sel_use_div ? DIV : RESP;
            DIV:     if (div_done) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            id_q      <= gnt_idx;
            res_q     <= fast[2*WIDTH-1:0];
            err_q     <= !sel_use_div && fast[2*WIDTH];
            use_div_q <= sel_use_div;
            is_mod_q  <= (sel_op == OP_MOD);
        end
    end

    arith_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (sel_a),
        .b     (sel_b),
        .done  (div_done),
        .quot  (div_quot),
        .rem   (div_rem)
    );

    // Response fields read as zero outside RESP so reset leaves them cleared.
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_valid ? id_q : '0;
    assign rsp_err    = rsp_valid && err_q;
    assign rsp_result = !rsp_valid ? '0 :
                        !use_div_q ? res_q :
                        is_mod_q   ? {{WIDTH{1'b0}}, div_rem} :
                                     {{WIDTH{1'b0}}, div_quot};

endmodule

// File: tb/tb_arith_req_scheduler.sv
// Bench for arith_req_scheduler: vector table, randomized transactions against
// an arithmetic reference model, and hand-written arbitration/reset sequences.
module tb_arith_req_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arith_req_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        int id; int op; int a; int b; int res; int err; int lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result straight from the arithmetic definitions.
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int err, output int lat);
        res = 0; err = 0; lat = 1;
        case (op)
            0: res = a + b;
            1: res = (a >= b) ? (a - b) : (a - b + 512);
            2: res = a * b;
            3: if (b == 0) begin res = 255; err = 1; end
               else begin res = a / b; lat = WIDTH + 1; end
            4: if (b == 0) begin res = a; err = 1; end
               else begin res = a % b; lat = WIDTH + 1; end
            default: err = 1;
        endcase
    endfunction

    task automatic run_txn(input int id, input int op, input int a, input int b,
                           input int exp_res, input int exp_err, input int exp_lat,
                           input int stall, input string tag);
        int lat;
        logic [31:0] exp_hold;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_op[id*3 +: 3] = op[2:0];
        req_a[id*8 +: 8]  = a[7:0];
        req_b[id*8 +: 8]  = b[7:0];
        rsp_ready = (stall == 0);
        #1;
        chk({tag, " grant"}, {28'd0, req_ready}, 32'd1 << id);
        step();
        req_valid = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " id"}, {30'd0, rsp_id}, id);
        chk({tag, " result"}, {16'd0, rsp_result}, exp_res);
        chk({tag, " err"}, {31'd0, rsp_err}, exp_err);
        exp_hold = {8'd0, 1'b1, id[1:0], exp_res[15:0], exp_err[0], 4'b0000};
        req_valid = '1;
        for (int s = 0; s < stall; s++) begin
            step();
            chk({tag, " hold"}, {8'd0, rsp_valid, rsp_id, rsp_result, rsp_err, req_ready}, exp_hold);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        chk({tag, " drain"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        int   r, e, l, seen;
        int   exp_order[5];

        tbl[0]  = '{0, 0, 200, 100, 300,    0, 1};
        tbl[1]  = '{1, 1, 3,   10,  'h1F9,  0, 1};
        tbl[2]  = '{1, 2, 10,  3,   30,     0, 1};
        tbl[3]  = '{2, 3, 10,  3,   3,      0, 9};
        tbl[4]  = '{2, 4, 10,  3,   1,      0, 9};
        tbl[5]  = '{3, 3, 7,   0,   'hFF,   1, 1};
        tbl[6]  = '{3, 4, 7,   0,   7,      1, 1};
        tbl[7]  = '{0, 5, 1,   1,   0,      1, 1};
        tbl[8]  = '{1, 2, 255, 255, 'hFE01, 0, 1};
        tbl[9]  = '{0, 0, 255, 255, 'h1FE,  0, 1};
        tbl[10] = '{2, 3, 255, 1,   255,    0, 9};
        tbl[11] = '{3, 4, 200, 7,   4,      0, 9};
        tbl[12] = '{0, 1, 5,   5,   0,      0, 1};
        tbl[13] = '{1, 7, 9,   4,   0,      1, 1};

        rst = 1'b1;
        req_valid = '1;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("reset fields", {13'd0, req_ready, rsp_valid, rsp_id, rsp_result, rsp_err}, 32'd0);
        rst = 1'b0;
        req_valid = '0;
        step();

        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].res, tbl[i].err, tbl[i].lat, i % 3, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 150; n++) begin
            int id, op, a, b, stall;
            id = $urandom_range(0, 3);
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(0, 255);
            stall = $urandom_range(0, 2);
            model(op, a, b, r, e, l);
            run_txn(id, op, a, b, r, e, l, stall, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a divide: leaves rr pointer at 3 before reset.
        req_valid = 4'b0100;
        req_op[6 +: 3] = 3'd3;
        req_a[16 +: 8] = 8'd10;
        req_b[16 +: 8] = 8'd3;
        rsp_ready = 1'b1;
        #1;
        step();
        req_valid = '0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst fields", {13'd0, req_ready, rsp_valid, rsp_id, rsp_result, rsp_err}, 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (rsp_valid === 1'b1) seen = 1;
        end
        chk("midrst no response", seen, 0);

        // All requesters valid: rotation must restart from requester 0.
        for (int i = 0; i < 4; i++) begin
            req_op[i*3 +: 3] = 3'd0;
            req_a[i*8 +: 8]  = 8'(i + 1);
            req_b[i*8 +: 8]  = 8'd10;
        end
        exp_order = '{0, 1, 2, 3, 0};
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("rr grant%0d", n), {28'd0, req_ready}, 32'd1 << exp_order[n]);
            step();
            chk($sformatf("rr rsp%0d", n), {13'd0, rsp_valid, rsp_id, rsp_result},
                {13'd0, 1'b1, 2'(exp_order[n]), 16'(exp_order[n] + 11)});
            step();
        end
        rsp_ready = 1'b0;
        #1;
        chk("stall grant", {28'd0, req_ready}, 32'd2);
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall hold%0d", c),
                {8'd0, rsp_valid, rsp_id, rsp_result, rsp_err, req_ready},
                {8'd0, 1'b1, 2'd1, 16'd12, 1'b0, 4'b0000});
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        chk("stall drain", {31'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
